// File: rtl/lsu_controller.sv
// Load/store unit: latches one core access, drives it to a ready-handshake data memory,
// and returns extended load data or a timeout fault to the core.
module lsu_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        misaligned_o,
    output logic        fault_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [31:0]   addr_reg, addr_next;
    logic [2:0]    size_reg, size_next;
    logic          we_reg, we_next;
    logic [31:0]   wd_reg, wd_next;
    logic [31:0]   rd_reg, rd_next;
    logic          fault_reg, fault_next;

    logic          bad_access;
    logic [3:0]    store_be;
    logic [31:0]   store_wd;
    logic [31:0]   load_ext;
    logic [31:0]   byte_shift, half_shift;

    // Illegal sizes (3/6/7) are treated like misalignment so the core traps on them too.
    always_comb begin
        bad_access = 1'b0;
        case (core_size_i)
            3'd0, 3'd4: bad_access = 1'b0;
            3'd1, 3'd5: bad_access = core_addr_i[0];
            3'd2:       bad_access = |core_addr_i[1:0];
            default:    bad_access = 1'b1;
        endcase
    end

    assign misaligned_o = core_req_i & (state_reg == IDLE) & bad_access;

    always_comb begin
        store_be = 4'b0000;
        store_wd = wd_reg;
        case (size_reg[1:0])
            2'd0: begin
                store_be = 4'b0001 << addr_reg[1:0];
                store_wd = {4{wd_reg[7:0]}};
            end
            2'd1: begin
                store_be = 4'b0011 << {addr_reg[1], 1'b0};
                store_wd = {2{wd_reg[15:0]}};
            end
            default: begin
                store_be = 4'b1111;
                store_wd = wd_reg;
            end
        endcase
    end

    assign byte_shift = mem_rd_i >> {addr_reg[1:0], 3'b000};
    assign half_shift = mem_rd_i >> {addr_reg[1], 4'b0000};

    always_comb begin
        case (size_reg)
            3'd0:    load_ext = {{24{byte_shift[7]}}, byte_shift[7:0]};
            3'd1:    load_ext = {{16{half_shift[15]}}, half_shift[15:0]};
            3'd4:    load_ext = {24'd0, byte_shift[7:0]};
            3'd5:    load_ext = {16'd0, half_shift[15:0]};
            default: load_ext = mem_rd_i;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        addr_next    = addr_reg;
        size_next    = size_reg;
        we_next      = we_reg;
        wd_next      = wd_reg;
        rd_next      = rd_reg;
        fault_next   = fault_reg;
        core_stall_o = 1'b0;
        fault_o      = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_be_o     = 4'b0000;
        mem_addr_o   = 32'd0;
        mem_wd_o     = 32'd0;
        case (state_reg)
            IDLE: begin
                fault_next = 1'b0;
                if (core_req_i && !bad_access) begin
                    addr_next    = core_addr_i;
                    size_next    = core_size_i;
                    we_next      = core_we_i;
                    wd_next      = core_wd_i;
                    core_stall_o = 1'b1;
                    state_next   = REQ;
                end
            end
            REQ: begin
                core_stall_o = 1'b1;
                mem_req_o    = 1'b1;
                mem_we_o     = we_reg;
                mem_be_o     = we_reg ? store_be : 4'b0000;
                mem_addr_o   = {addr_reg[31:2], 2'b00};
                mem_wd_o     = store_wd;
                // Ready is tested first so a late ready on the last allowed cycle still succeeds.
                if (mem_ready_i) begin
                    state_next = DONE;
                    cnt_next   = '0;
                    if (!we_reg) begin
                        rd_next = load_ext;
                    end
                end else if (cnt_reg == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_next = DONE;
                    cnt_next   = '0;
                    fault_next = 1'b1;
                    rd_next    = 32'd0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            DONE: begin
                fault_o    = fault_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign core_rd_o = rd_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            addr_reg  <= 32'd0;
            size_reg  <= 3'd0;
            we_reg    <= 1'b0;
            wd_reg    <= 32'd0;
            rd_reg    <= 32'd0;
            fault_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            size_reg  <= size_next;
            we_reg    <= we_next;
            wd_reg    <= wd_next;
            rd_reg    <= rd_next;
            fault_reg <= fault_next;
        end
    end

endmodule

// File: tb/tb_lsu_controller.sv
// Scoreboard bench for lsu_controller: stimulus pushes expected memory and completion
// events into queues, a negedge monitor pops and compares them.
module tb_lsu_controller;

    localparam int unsigned TMO = 16;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        core_req_i, core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i, core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o, misaligned_o, fault_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wd_o, mem_rd_i;
    logic        mem_ready_i;

    lsu_controller #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
        .core_addr_i(core_addr_i), .core_wd_i(core_wd_i),
        .core_rd_o(core_rd_o), .core_stall_o(core_stall_o),
        .misaligned_o(misaligned_o), .fault_o(fault_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o),
        .mem_rd_i(mem_rd_i), .mem_ready_i(mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        chk_wd;
    } mem_exp_t;

    typedef struct packed {
        logic        fault;
        logic [31:0] rd;
        logic        chk_rd;
    } done_exp_t;

    mem_exp_t  mem_q[$];
    done_exp_t done_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: memory handshakes and completions (stall falling after a stalled cycle).
    initial begin
        logic prev_stall;
        mem_exp_t  me;
        done_exp_t de;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                prev_stall = 1'b0;
            end else begin
                if (mem_req_o && mem_ready_i) begin
                    if (mem_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL mem_unexpected: got addr %h expected no request", mem_addr_o);
                    end else begin
                        me = mem_q.pop_front();
                        check("mem_we", {31'd0, mem_we_o}, {31'd0, me.we});
                        check("mem_be", {28'd0, mem_be_o}, {28'd0, me.be});
                        check("mem_addr", mem_addr_o, me.addr);
                        if (me.chk_wd) check("mem_wd", mem_wd_o, me.wd);
                    end
                end
                if (prev_stall && !core_stall_o) begin
                    if (done_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL done_unexpected: got completion expected none");
                    end else begin
                        de = done_q.pop_front();
                        check("done_fault", {31'd0, fault_o}, {31'd0, de.fault});
                        if (de.chk_rd) check("done_rd", core_rd_o, de.rd);
                    end
                end
                prev_stall = core_stall_o;
            end
        end
    end

    task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] mrd, input int waits,
                          input bit tmo, input logic [3:0] ebe, input logic [31:0] ewd,
                          input logic [31:0] erd, input bit chk_rd);
        int n;
        bit fin;
        @(posedge clk_i); #1;
        core_req_i = 1'b1; core_we_i = we; core_size_i = size;
        core_addr_i = addr; core_wd_i = wd;
        if (!tmo) mem_q.push_back('{we, ebe, {addr[31:2], 2'b00}, ewd, we});
        done_q.push_back('{tmo, erd, chk_rd});
        @(negedge clk_i);
        check("issue_stall", {31'd0, core_stall_o}, 32'd1);
        check("issue_misaligned", {31'd0, misaligned_o}, 32'd0);
        @(posedge clk_i); #1;
        core_req_i = 1'b0;
        n = 0;
        fin = 0;
        while (!fin) begin
            mem_ready_i = (!tmo && n == waits);
            mem_rd_i = mrd;
            @(negedge clk_i);
            check("req_stall", {31'd0, core_stall_o}, 32'd1);
            @(posedge clk_i); #1;
            if (mem_ready_i || (tmo && n == int'(TMO) - 1)) fin = 1;
            else n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL access_bound: got no completion expected one");
                fin = 1;
            end
        end
        mem_ready_i = 1'b0;
        @(negedge clk_i);
        check("done_stall", {31'd0, core_stall_o}, 32'd0);
        check("done_memreq", {31'd0, mem_req_o}, 32'd0);
    endtask

    task automatic misaligned(input logic we, input logic [2:0] size, input logic [31:0] addr);
        @(posedge clk_i); #1;
        core_req_i = 1'b1; core_we_i = we; core_size_i = size;
        core_addr_i = addr; core_wd_i = 32'hFFFF_FFFF;
        @(negedge clk_i);
        check("mis_flag", {31'd0, misaligned_o}, 32'd1);
        check("mis_stall", {31'd0, core_stall_o}, 32'd0);
        check("mis_memreq", {31'd0, mem_req_o}, 32'd0);
        @(posedge clk_i); #1;
        core_req_i = 1'b0;
        @(negedge clk_i);
        check("mis_memreq_after", {31'd0, mem_req_o}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd"}, core_rd_o, 32'd0);
        check({tag, "_stall"}, {31'd0, core_stall_o}, 32'd0);
        check({tag, "_fault"}, {31'd0, fault_o}, 32'd0);
        check({tag, "_memreq"}, {31'd0, mem_req_o}, 32'd0);
        check({tag, "_memwe"}, {31'd0, mem_we_o}, 32'd0);
        check({tag, "_membe"}, {28'd0, mem_be_o}, 32'd0);
        check({tag, "_memaddr"}, mem_addr_o, 32'd0);
        check({tag, "_memwd"}, mem_wd_o, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0;
        core_req_i = 1'b0; core_we_i = 1'b0; core_size_i = 3'd0;
        core_addr_i = 32'd0; core_wd_i = 32'd0;
        mem_rd_i = 32'd0; mem_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_all_zero("reset");
        check("reset_mis", {31'd0, misaligned_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        // we, size, addr, wd, mem_rd, waits, timeout, be, wd_exp, rd_exp, chk_rd
        access(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 4'b0000, 32'h0, 32'hDEADBEEF, 1);
        access(1'b1, 3'd0, 32'h103, 32'h12345678, 32'h0, 0, 0, 4'b1000, 32'h78787878, 32'h0, 0);
        access(1'b0, 3'd0, 32'h102, 32'h0, 32'h0080FF00, 0, 0, 4'b0000, 32'h0, 32'hFFFFFF80, 1);
        access(1'b0, 3'd4, 32'h102, 32'h0, 32'h0080FF00, 0, 0, 4'b0000, 32'h0, 32'h00000080, 1);
        access(1'b1, 3'd1, 32'h102, 32'hAAAA5555, 32'h0, 1, 0, 4'b1100, 32'h55555555, 32'h0, 0);
        access(1'b0, 3'd1, 32'h102, 32'h0, 32'h80017FFF, 2, 0, 4'b0000, 32'h0, 32'hFFFF8001, 1);
        access(1'b0, 3'd5, 32'h100, 32'h0, 32'h12348765, 0, 0, 4'b0000, 32'h0, 32'h00008765, 1);
        access(1'b0, 3'd1, 32'h100, 32'h0, 32'h12348765, 3, 0, 4'b0000, 32'h0, 32'hFFFF8765, 1);
        access(1'b1, 3'd2, 32'h104, 32'hCAFEF00D, 32'h0, 1, 0, 4'b1111, 32'hCAFEF00D, 32'h0, 0);
        access(1'b1, 3'd0, 32'h101, 32'h000000A5, 32'h0, 0, 0, 4'b0010, 32'hA5A5A5A5, 32'h0, 0);
        access(1'b0, 3'd1, 32'h200, 32'h0, 32'h0, 0, 1, 4'b0000, 32'h0, 32'h0, 1);
        access(1'b0, 3'd2, 32'h108, 32'h0, 32'h01020304, TMO - 1, 0, 4'b0000, 32'h0, 32'h01020304, 1);

        misaligned(1'b0, 3'd2, 32'h102);
        misaligned(1'b0, 3'd1, 32'h101);
        misaligned(1'b1, 3'd1, 32'h203);
        misaligned(1'b0, 3'd5, 32'h105);
        misaligned(1'b0, 3'd3, 32'h100);
        misaligned(1'b1, 3'd7, 32'h100);

        // Abandon an access with reset while it waits in REQ.
        @(posedge clk_i); #1;
        core_req_i = 1'b1; core_we_i = 1'b1; core_size_i = 3'd2;
        core_addr_i = 32'h300; core_wd_i = 32'h55AA55AA;
        @(posedge clk_i); #1;
        core_req_i = 1'b0;
        @(posedge clk_i); #1;
        check("rst_pre_memreq", {31'd0, mem_req_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        check_all_zero("midrst");
        @(posedge clk_i); #1;
        mem_ready_i = 1'b1;
        @(posedge clk_i); #1;
        mem_ready_i = 1'b0;
        rst_ni = 1'b1;
        repeat (2) begin
            @(negedge clk_i);
            check("post_rst_fault", {31'd0, fault_o}, 32'd0);
            check("post_rst_memreq", {31'd0, mem_req_o}, 32'd0);
        end
        access(1'b0, 3'd0, 32'h303, 32'h0, 32'h7F000000, 1, 0, 4'b0000, 32'h0, 32'h0000007F, 1);

        repeat (3) @(posedge clk_i);
        check("mem_q_left", mem_q.size(), 32'd0);
        check("done_q_left", done_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
